// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request feeding a prefetch queue toward decode.
// Define IF_STAGE_BYPASS_EN to present a response on id_* in the cycle it arrives at an empty queue.
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [63:0] id_pc
);
    localparam int            PW   = $clog2(QDEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;
    state_t state, state_next;

    logic [63:0]   fetch_pc;
    logic [63:0]   req_addr;
    logic          started;
    logic [63:0]   q_pc   [QDEPTH];
    logic [31:0]   q_inst [QDEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;

    logic accept, push, pop, bypass_hit, has_head;

    // No request may issue in the redirect cycle, so the new target is first fetched a cycle later.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            FETCH: begin
                imem_req = reset && started && !redirect_valid && (count < FULL);
                if (imem_req && !imem_ack) state_next = WAIT;
            end
            WAIT: begin
                imem_req = reset;
                if (imem_ack)            state_next = FETCH;
                else if (redirect_valid) state_next = DISCARD;
            end
            DISCARD: begin
                imem_req = reset;
                if (imem_ack) state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    assign imem_addr = (state == FETCH) ? fetch_pc : req_addr;
    assign accept    = imem_req && imem_ack && (state != DISCARD) && !redirect_valid;
    assign has_head  = reset && (count != '0);

`ifdef IF_STAGE_BYPASS_EN
    assign bypass_hit = reset && (count == '0) && accept;
    assign push       = accept && !(bypass_hit && id_ready);
`else
    assign bypass_hit = 1'b0;
    assign push       = accept;
`endif

    assign pop      = has_head && id_ready && !redirect_valid;
    assign id_valid = has_head || bypass_hit;
    assign id_inst  = has_head ? q_inst[head] : (bypass_hit ? imem_rdata : 32'h0);
    assign id_pc    = has_head ? q_pc[head]   : (bypass_hit ? imem_addr  : 64'h0);

    // started keeps imem_req low for the first cycle after reset so stale acks fall on an idle bus.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            started  <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            state   <= state_next;
            started <= 1'b1;
            if (state == FETCH && imem_req) req_addr <= fetch_pc;
            if (redirect_valid)   fetch_pc <= redirect_pc & ~64'h3;
            else if (accept)      fetch_pc <= fetch_pc + 64'd4;
            if (redirect_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]   <= imem_addr;
            q_inst[tail] <= imem_rdata;
        end
    end

endmodule
